seg7_scan_driver: RTL and testbench

- Time-multiplexes NUM_DIGITS 7-segment patterns onto one shared segment bus with per-digit anode enables, for common-anode multi-digit displays.
- Sits directly downstream of the 4-bit ALU-to-7-segment decoders. Each decoder's 7-bit pattern is concatenated into seg_in.
- A load strobe captures the patterns into a shadow register. The shadow is applied only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seg7_scan_driver.sv | 162 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver for common-anode displays with tear-free frame updates.
// Optional anti-ghosting blanking at the start of each digit slot is enabled by defining SEG_BLANK_EN.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 100000,
    parameter int BLANK      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [7*NUM_DIGITS-1:0] seg_in,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_pulse
);

    localparam int DW = 7 * NUM_DIGITS;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK);

`ifdef SEG_BLANK_EN
    localparam logic BLANK_ON = 1'b1;
`else
    localparam logic BLANK_ON = 1'b0;
`endif

    logic [PW-1:0] presc_r;
    logic [IW-1:0] idx_r;
    logic [DW-1:0] shadow_r;
    logic [DW-1:0] disp_r;
    logic          pend_r;

    logic [PW-1:0]         presc_nxt_s;
    logic [IW-1:0]         idx_nxt_s;
    logic                  wrap_s;
    logic                  boundary_s;
    logic                  blank_s;
    logic [6:0]            seg_nxt_s;
    logic [NUM_DIGITS-1:0] an_nxt_s;

    function automatic logic [6:0] digit_pattern(input logic [DW-1:0] bus,
                                                 input logic [IW-1:0] sel);
        logic [6:0] pat;
        pat = 7'h00;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel == IW'(i)) begin
                pat = bus[7*i +: 7];
            end else begin
                pat = pat;
            end
        end
        return pat;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] anode_select(input logic [IW-1:0] sel);
        logic [NUM_DIGITS-1:0] an;
        an = {NUM_DIGITS{1'b1}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel == IW'(i)) begin
                an[i] = 1'b0;
            end else begin
                an[i] = 1'b1;
            end
        end
        return an;
    endfunction

    // Prescaler / digit index next state and frame-boundary detection.
    always_comb begin
        presc_nxt_s = {PW{1'b0}};
        idx_nxt_s   = {IW{1'b0}};
        wrap_s      = (presc_r == PRESC_LAST);
        boundary_s  = wrap_s && (idx_r == IDX_LAST);
        if (!en) begin
            presc_nxt_s = {PW{1'b0}};
            idx_nxt_s   = {IW{1'b0}};
        end else if (wrap_s) begin
            presc_nxt_s = {PW{1'b0}};
            if (idx_r == IDX_LAST) begin
                idx_nxt_s = {IW{1'b0}};
            end else begin
                idx_nxt_s = idx_r + IW'(1);
            end
        end else begin
            presc_nxt_s = presc_r + PW'(1);
            idx_nxt_s   = idx_r;
        end
    end

    // Segment/anode drive for the digit selected by the current scan position.
    always_comb begin
        seg_nxt_s = 7'h7F;
        an_nxt_s  = {NUM_DIGITS{1'b1}};
        blank_s   = BLANK_ON && (presc_r < BLANK_END);
        if (en) begin
            seg_nxt_s = ~digit_pattern(disp_r, idx_r);
            if (blank_s) begin
                an_nxt_s = {NUM_DIGITS{1'b1}};
            end else begin
                an_nxt_s = anode_select(idx_r);
            end
        end else begin
            seg_nxt_s = 7'h7F;
            an_nxt_s  = {NUM_DIGITS{1'b1}};
        end
    end

    // Scan counters and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= {PW{1'b0}};
            idx_r   <= {IW{1'b0}};
            seg_out <= 7'h7F;
            an_out  <= {NUM_DIGITS{1'b1}};
        end else begin
            presc_r <= presc_nxt_s;
            idx_r   <= idx_nxt_s;
            seg_out <= seg_nxt_s;
            an_out  <= an_nxt_s;
        end
    end

    // Shadow capture and display update; while dark, pending contents apply immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r    <= {DW{1'b0}};
            disp_r      <= {DW{1'b0}};
            pend_r      <= 1'b0;
            frame_pulse <= 1'b0;
        end else begin
            frame_pulse <= 1'b0;
            if (!en) begin
                if (load) begin
                    shadow_r <= seg_in;
                end
                if (pend_r) begin
                    disp_r <= shadow_r;
                end
                pend_r <= load;
            end else if (boundary_s) begin
                if (load) begin
                    disp_r      <= seg_in;
                    pend_r      <= 1'b0;
                    frame_pulse <= 1'b1;
                end else if (pend_r) begin
                    disp_r      <= shadow_r;
                    pend_r      <= 1'b0;
                    frame_pulse <= 1'b1;
                end
            end else if (load) begin
                shadow_r <= seg_in;
                pend_r   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 4 cycles per slot, blank of 1 when SEG_BLANK_EN).
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int DV = 4;
    localparam int BL = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          load;
    logic [27:0]   seg_in;
    logic [6:0]    seg_out;
    logic [3:0]    an_out;
    logic          frame_pulse;

    seg7_scan_driver #(.NUM_DIGITS(ND), .DIV(DV), .BLANK(BL)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .seg_in(seg_in),
        .seg_out(seg_out), .an_out(an_out), .frame_pulse(frame_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] an;
        logic       fp;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    int         m_d = 0;
    int         m_c = 0;
    logic [6:0] m_seg [4];

    localparam logic [27:0] P1    = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    localparam logic [27:0] P2    = {7'h5E, 7'h39, 7'h7C, 7'h77};
    localparam logic [27:0] ALL7F = {4{7'h7F}};
    localparam logic [27:0] JUNK  = {4{7'h08}};

    task automatic push(input logic [6:0] s, input logic [3:0] a, input logic f, input string nm);
        exp_t e;
        e.seg  = s;
        e.an   = a;
        e.fp   = f;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic set_segs(input logic [6:0] d0, input logic [6:0] d1,
                            input logic [6:0] d2, input logic [6:0] d3);
        m_seg[0] = d0;
        m_seg[1] = d1;
        m_seg[2] = d2;
        m_seg[3] = d3;
    endtask

    // A cycle in reset or with en low: outputs dark, scan restarts at digit 0.
    task automatic dark_step(input logic r, input logic e_in, input logic ld,
                             input logic [27:0] sin, input string nm);
        @(negedge clk);
        rst = r; en = e_in; load = ld; seg_in = sin;
        push(7'h7F, 4'hF, 1'b0, nm);
        m_d = 0;
        m_c = 0;
    endtask

    task automatic scan_step(input logic ld, input logic [27:0] sin,
                             input logic fp_exp, input string nm);
        logic [3:0] one;
        logic [3:0] a;
        one = 4'b0001;
        a   = ~(one << m_d);
`ifdef SEG_BLANK_EN
        if (m_c == 0) a = 4'hF;
`endif
        @(negedge clk);
        rst = 1'b0; en = 1'b1; load = ld; seg_in = sin;
        push(m_seg[m_d], a, fp_exp, nm);
        m_c++;
        if (m_c == DV) begin
            m_c = 0;
            m_d = (m_d + 1) % ND;
        end
    endtask

    task automatic run(input int n, input string nm);
        for (int i = 0; i < n; i++) scan_step(1'b0, 28'h0, 1'b0, nm);
    endtask

    // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if ({seg_out, an_out, frame_pulse} !== {mon_e.seg, mon_e.an, mon_e.fp}) begin
                errors++;
                $display("FAIL %s: got seg=%h an=%h fp=%b, want seg=%h an=%h fp=%b",
                         mon_e.name, seg_out, an_out, frame_pulse,
                         mon_e.seg, mon_e.an, mon_e.fp);
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; seg_in = 28'h0;
        set_segs(7'h7F, 7'h7F, 7'h7F, 7'h7F);

        // Reset held with en and load high; display stays blank afterwards.
        repeat (3) dark_step(1'b1, 1'b1, 1'b1, P1, "reset");
        run(4, "post_reset");

        // Load while dark, then scan two full frames with no frame pulse.
        dark_step(1'b0, 1'b0, 1'b0, 28'h0, "idle_dark");
        dark_step(1'b0, 1'b0, 1'b1, P1, "load_dark");
        dark_step(1'b0, 1'b0, 1'b0, 28'h0, "apply_dark");
        set_segs(7'h40, 7'h79, 7'h24, 7'h30);
        run(32, "basic_scan");

        // Two loads mid-frame; last wins, applied only at the wrap.
        run(5, "pre_update");
        scan_step(1'b1, JUNK, 1'b0, "load_junk");
        run(2, "old_digit1");
        scan_step(1'b1, ALL7F, 1'b0, "load_all");
        run(6, "old_tail");
        scan_step(1'b0, 28'h0, 1'b1, "wrap_pulse");
        set_segs(7'h00, 7'h00, 7'h00, 7'h00);
        run(16, "new_frame");

        // Load exactly on the wrap cycle bypasses the shadow.
        run(15, "pre_collide");
        scan_step(1'b1, P2, 1'b1, "collide");
        set_segs(7'h08, 7'h03, 7'h46, 7'h21);
        run(16, "after_collide");

        // Drop en mid-slot on digit 2, restart, then reset mid-frame.
        run(9, "pre_abort");
        dark_step(1'b0, 1'b0, 1'b0, 28'h0, "en_drop");
        dark_step(1'b0, 1'b0, 1'b0, 28'h0, "en_low");
        run(8, "restart");
        dark_step(1'b1, 1'b1, 1'b0, 28'h0, "mid_rst");
        set_segs(7'h7F, 7'h7F, 7'h7F, 7'h7F);
        run(16, "post_rst");

        for (int i = 0; i < 8 && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
